multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Parametrised second-generation multicycle control FSM for the TinyV core. It sequences fetch, decode, execute, memory and write-back and drives the existing datapath selects. Over the first-generation unit it adds:
- a req/ready memory handshake with wait states and a timeout;
- conditional branches qualified by the ALU zero flag;
- a HALT instruction;
- an illegal-opcode / bus-error trap that vectors the PC.

Parameters:
OPC_W, 4, opcode field width (minimum 3).
ALUOP_W, 2, width of aluOp.
MEM_TIMEOUT, 15, wait cycles allowed before bus error; 0 disables the timeout.
TRAP_EN, 1, 1 = illegal opcode or bus error enters TRAP; 0 = silently return to FETCH.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
codop  in  OPC_W  opcode from the instruction register
aluZero  in  1  ALU zero flag, valid in the BR state
memReady  in  1  memory completed the current request this cycle
memReq  out  1  memory request, held until memReady
memWrCtl  out  1  store strobe, qualified by memReq
memAdrSel  out  1  0 = PC address, 1 = ALU result address
irWr  out  1  instruction register load
pcCtrl  out  1  PC write enable
pcWrSel  out  2  00 = ALU, 01 = branch target, 10 = jump target, 11 = trap vector
aluOp  out  ALUOP_W  ALU operation
aluASel  out  1  ALU A mux select
aluBSel  out  2  ALU B mux select
regWCtl  out  1  register file write enable
regDataSel  out  1  0 = memory data, 1 = ALU result
regWSel  out  2  destination field select
state  out  4  current state encoding, for debug
illegal  out  1  sticky: illegal opcode seen
busErr  out  1  sticky: memory timeout occurred
halted  out  1  FSM is in HALT

Behaviour:
- Reset asserted (reset = 0): state = FETCH, wait counter = 0, illegal = busErr = 0, all outputs 0. Release is synchronous to the next clk edge. Reset mid-handshake drops memReq immediately.
- All outputs are Moore-decoded from state, except pcCtrl/irWr/regWCtl in wait states, which are gated by memReady in the same cycle. Every output not listed for a state is 0.
- FETCH: memReq = 1, memAdrSel = 0, aluOp = ADD, aluBSel = 00 (PC+4).
  - memReady = 0: stay in FETCH, all signals held stable.
  - memReady = 1: irWr = 1, pcCtrl = 1, pcWrSel = 00, next state DECODE.
- DECODE: aluOp = ADD, aluBSel = 10 (branch target precompute). Next state by codop:
  - ALU -> ALU_EX; ALUI -> ALUI_EX; LD or ST -> LDST_ADDR; BR -> BR; JMP -> JMP; JMPI -> JMPI; HALT -> HALT.
  - Any other codop: illegal <= 1, next state TRAP (TRAP_EN = 1) or FETCH (TRAP_EN = 0).
- ALU_EX: aluASel = 1, aluBSel = 00 -> ALU_WB. ALU_WB: regWCtl = 1, regDataSel = 1, regWSel = 00 -> FETCH.
- ALUI_EX: aluASel = 1, aluBSel = 01 -> ALUI_WB. ALUI_WB: as ALU_WB but regWSel = 01 -> FETCH.
- BR: aluOp = CMP, aluASel = 1, pcWrSel = 01, pcCtrl = aluZero -> FETCH.
- JMP: pcWrSel = 10, pcCtrl = 1 -> FETCH. JMPI: pcWrSel = 00, pcCtrl = 1 -> FETCH.
- LDST_ADDR: aluOp = ADD, aluASel = 1, aluBSel = 10. codop LD -> LD_MEM, ST -> ST_MEM.
- LD_MEM: memReq = 1, memAdrSel = 1; stays until memReady, then -> LD_WB.
- LD_WB: regWCtl = 1, regDataSel = 0, regWSel = 01 -> FETCH.
- ST_MEM: memReq = memWrCtl = memAdrSel = 1; on memReady -> FETCH.
- Wait counter (width clog2(MEM_TIMEOUT+1)):
  - Increments each cycle in FETCH/LD_MEM/ST_MEM while memReady = 0; clears on any state change.
  - If it reaches MEM_TIMEOUT with memReady = 0 and MEM_TIMEOUT > 0: busErr <= 1, next state TRAP (TRAP_EN = 1) or FETCH (TRAP_EN = 0).
  - memReady = 1 in the same cycle as the timeout: memReady wins and the access completes normally.
- TRAP: pcWrSel = 11, pcCtrl = 1, single cycle -> FETCH.
- HALT: halted = 1, no strobes; leaves only on reset.
- Unused state encodings -> FETCH.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (15 states, 4 bits);
  - opcode constants OP_ALU = 0, OP_ALUI = 1, OP_LD = 2, OP_ST = 3, OP_BR = 4, OP_JMP = 5, OP_JMPI = 6, OP_HALT = 7;
  - ALU_ADD = 0, ALU_CMP = 1;
  - pcWrSel encodings.
- One sub-module, ctrl_wait_timer: a parametrised counter with clear/enable and a timeout output.

Test Plan:
- Reset release, memReady tied 1, codop = OP_ALU -> states FETCH, DECODE, ALU_EX, ALU_WB, FETCH; regWCtl = 1 only in ALU_WB with regDataSel = 1.
- codop = OP_LD, memReady low for 3 cycles in LD_MEM -> memReq held high for 4 cycles with memAdrSel = 1, then LD_WB with regWCtl = 1, regDataSel = 0.
- codop = OP_BR: aluZero = 1 -> pcCtrl = 1, pcWrSel = 01. Repeat with aluZero = 0 -> pcCtrl = 0, next state FETCH.
- codop = 4'hF with TRAP_EN = 1 -> illegal = 1, TRAP for one cycle with pcWrSel = 11, pcCtrl = 1, then FETCH; illegal still 1 afterwards.
- MEM_TIMEOUT = 15, memReady never asserted in ST_MEM -> after 15 wait cycles busErr = 1 and TRAP. Separately, memReady = 1 exactly on the 15th cycle -> normal completion, busErr = 0.
- codop = OP_HALT -> halted = 1 indefinitely. Pulse reset low mid-LD_MEM -> memReq = 0 immediately; after release the state is FETCH and illegal = busErr = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the TinyV multicycle controller: state codes,
// opcode and ALU-operation constants, and PC write-select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_ALU_EX    = 4'd2,
        S_ALU_WB    = 4'd3,
        S_ALUI_EX   = 4'd4,
        S_ALUI_WB   = 4'd5,
        S_LDST_ADDR = 4'd6,
        S_LD_MEM    = 4'd7,
        S_LD_WB     = 4'd8,
        S_ST_MEM    = 4'd9,
        S_BR        = 4'd10,
        S_JMP       = 4'd11,
        S_JMPI      = 4'd12,
        S_TRAP      = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    localparam int unsigned OP_ALU  = 0;
    localparam int unsigned OP_ALUI = 1;
    localparam int unsigned OP_LD   = 2;
    localparam int unsigned OP_ST   = 3;
    localparam int unsigned OP_BR   = 4;
    localparam int unsigned OP_JMP  = 5;
    localparam int unsigned OP_JMPI = 6;
    localparam int unsigned OP_HALT = 7;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_CMP = 1;

    localparam logic [1:0] PCW_ALU  = 2'b00;
    localparam logic [1:0] PCW_BR   = 2'b01;
    localparam logic [1:0] PCW_JMP  = 2'b10;
    localparam logic [1:0] PCW_TRAP = 2'b11;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter: counts enabled cycles up to MAX and flags the
// limit; MAX = 0 never flags.
module ctrl_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (MAX > 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// TinyV multicycle control FSM: fetch/decode/execute/memory/write-back with
// a req/ready memory handshake, wait timeout, branches, HALT and trap.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = 4,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TRAP_EN     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   codop,
    input  logic               aluZero,
    input  logic               memReady,
    output logic               memReq,
    output logic               memWrCtl,
    output logic               memAdrSel,
    output logic               irWr,
    output logic               pcCtrl,
    output logic [1:0]         pcWrSel,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               aluASel,
    output logic [1:0]         aluBSel,
    output logic               regWCtl,
    output logic               regDataSel,
    output logic [1:0]         regWSel,
    output logic [3:0]         state,
    output logic               illegal,
    output logic               busErr,
    output logic               halted
);

    localparam logic [ALUOP_W-1:0] AOP_ADD = ALUOP_W'(ALU_ADD);
    localparam logic [ALUOP_W-1:0] AOP_CMP = ALUOP_W'(ALU_CMP);
    localparam state_t S_FAULT = (TRAP_EN != 0) ? S_TRAP : S_FETCH;

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic        busErr_q, busErr_d;
    logic        wait_en, wait_clr, wait_to, to_hit;
    logic [31:0] op;

    assign op     = 32'(codop);
    assign to_hit = wait_to && !memReady;

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        busErr_d   = busErr_q;
        wait_en    = 1'b0;
        memReq     = 1'b0;
        memWrCtl   = 1'b0;
        memAdrSel  = 1'b0;
        irWr       = 1'b0;
        pcCtrl     = 1'b0;
        pcWrSel    = PCW_ALU;
        aluOp      = AOP_ADD;
        aluASel    = 1'b0;
        aluBSel    = 2'b00;
        regWCtl    = 1'b0;
        regDataSel = 1'b0;
        regWSel    = 2'b00;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memReq  = 1'b1;
                wait_en = !memReady;
                if (memReady) begin
                    irWr    = 1'b1;
                    pcCtrl  = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    busErr_d = 1'b1;
                    state_d  = S_FAULT;
                end
            end
            S_DECODE: begin
                aluBSel = 2'b10;
                case (op)
                    OP_ALU:        state_d = S_ALU_EX;
                    OP_ALUI:       state_d = S_ALUI_EX;
                    OP_LD, OP_ST:  state_d = S_LDST_ADDR;
                    OP_BR:         state_d = S_BR;
                    OP_JMP:        state_d = S_JMP;
                    OP_JMPI:       state_d = S_JMPI;
                    OP_HALT:       state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FAULT;
                    end
                endcase
            end
            S_ALU_EX: begin
                aluASel = 1'b1;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                regWCtl    = 1'b1;
                regDataSel = 1'b1;
                state_d    = S_FETCH;
            end
            S_ALUI_EX: begin
                aluASel = 1'b1;
                aluBSel = 2'b01;
                state_d = S_ALUI_WB;
            end
            S_ALUI_WB: begin
                regWCtl    = 1'b1;
                regDataSel = 1'b1;
                regWSel    = 2'b01;
                state_d    = S_FETCH;
            end
            S_LDST_ADDR: begin
                aluASel = 1'b1;
                aluBSel = 2'b10;
                if (op == OP_LD) begin
                    state_d = S_LD_MEM;
                end else if (op == OP_ST) begin
                    state_d = S_ST_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_LD_MEM, S_ST_MEM: begin
                memReq    = 1'b1;
                memAdrSel = 1'b1;
                memWrCtl  = (state_q == S_ST_MEM);
                wait_en   = !memReady;
                if (memReady) begin
                    state_d = (state_q == S_LD_MEM) ? S_LD_WB : S_FETCH;
                end else if (to_hit) begin
                    busErr_d = 1'b1;
                    state_d  = S_FAULT;
                end
            end
            S_LD_WB: begin
                regWCtl = 1'b1;
                regWSel = 2'b01;
                state_d = S_FETCH;
            end
            S_BR: begin
                aluOp   = AOP_CMP;
                aluASel = 1'b1;
                pcWrSel = PCW_BR;
                pcCtrl  = aluZero;
                state_d = S_FETCH;
            end
            S_JMP: begin
                pcWrSel = PCW_JMP;
                pcCtrl  = 1'b1;
                state_d = S_FETCH;
            end
            S_JMPI: begin
                pcCtrl  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                pcWrSel = PCW_TRAP;
                pcCtrl  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Outputs are forced low while reset is held so memReq drops at once.
        if (!reset) begin
            memReq    = 1'b0;
            irWr      = 1'b0;
            pcCtrl    = 1'b0;
            aluOp     = '0;
            halted    = 1'b0;
            memWrCtl  = 1'b0;
            memAdrSel = 1'b0;
            pcWrSel   = '0;
            aluASel   = 1'b0;
            aluBSel   = '0;
            regWCtl   = 1'b0;
            regDataSel = 1'b0;
            regWSel   = '0;
        end
    end

    // A timeout that falls back to FETCH without a state change still restarts the count.
    assign wait_clr = (state_d != state_q) || to_hit;

    ctrl_wait_timer #(.MAX(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (wait_to)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            busErr_q  <= busErr_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign busErr  = busErr_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Instruction-level reference model for multicycle_ctrl: each instruction is
// expanded into expected per-cycle output vectors, then replayed on the DUT.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int MEM_TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] codop;
    logic       aluZero, memReady;
    logic       memReq, memWrCtl, memAdrSel, irWr, pcCtrl;
    logic [1:0] pcWrSel, aluOp, aluBSel, regWSel;
    logic       aluASel, regWCtl, regDataSel;
    logic [3:0] state;
    logic       illegal, busErr, halted;

    multicycle_ctrl #(.OPC_W(4), .ALUOP_W(2), .MEM_TIMEOUT(MEM_TO), .TRAP_EN(1)) dut (
        .clk(clk), .reset(reset), .codop(codop), .aluZero(aluZero), .memReady(memReady),
        .memReq(memReq), .memWrCtl(memWrCtl), .memAdrSel(memAdrSel), .irWr(irWr),
        .pcCtrl(pcCtrl), .pcWrSel(pcWrSel), .aluOp(aluOp), .aluASel(aluASel),
        .aluBSel(aluBSel), .regWCtl(regWCtl), .regDataSel(regDataSel), .regWSel(regWSel),
        .state(state), .illegal(illegal), .busErr(busErr), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          rst;
        logic [3:0]  op;
        bit          ready;
        bit          zero;
        logic [22:0] exp;
    } cyc_t;

    cyc_t       plan[$];
    bit         m_ill, m_bus;
    logic [3:0] cur_op;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [22:0] ev(input state_t st, input bit mreq, input bit mwr,
                                       input bit madr, input bit irw, input bit pcc,
                                       input logic [1:0] pcsel, input logic [1:0] aop,
                                       input bit asel, input logic [1:0] bsel, input bit rw,
                                       input bit rds, input logic [1:0] rws);
        return {4'(st), mreq, mwr, madr, irw, pcc, pcsel, aop, asel, bsel, rw, rds, rws,
                m_ill, m_bus, (st == S_HALT)};
    endfunction

    task automatic push(input string tag, input bit ready, input bit zero, input logic [22:0] e);
        cyc_t c;
        c.tag = tag; c.rst = 1'b0; c.op = cur_op; c.ready = ready; c.zero = zero; c.exp = e;
        plan.push_back(c);
    endtask

    task automatic push_reset(input string tag);
        cyc_t c;
        m_ill = 1'b0;
        m_bus = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c.tag = tag; c.rst = 1'b1; c.op = cur_op; c.ready = 1'($urandom);
            c.zero = 1'($urandom); c.exp = '0;
            plan.push_back(c);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // One memory access: wait_n idle cycles then ready, unless the timeout
    // (MEM_TO idle cycles already spent) or a reset at abort_at comes first.
    task automatic mem_phase(input string tag, input state_t st, input int wait_n,
                             input int abort_at, output bit ok);
        bit wr   = (st == S_ST_MEM);
        bit adr  = (st != S_FETCH);
        bit fet  = (st == S_FETCH);
        ok = 1'b0;
        for (int k = 0; k <= MEM_TO; k++) begin
            if (abort_at >= 0 && k == abort_at) begin
                push_reset({tag, "_abort"});
                return;
            end
            if (k == wait_n) begin
                push({tag, "_done"}, 1'b1, rb(),
                     ev(st, 1, wr, adr, fet, fet, 2'b00, 2'd0, 0, 2'b00, 0, 0, 2'b00));
                ok = 1'b1;
                return;
            end
            push({tag, "_wait"}, 1'b0, rb(),
                 ev(st, 1, wr, adr, 0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 2'b00));
            if (k == MEM_TO) begin
                m_bus = 1'b1;
                push({tag, "_trap"}, rb(), rb(),
                     ev(S_TRAP, 0, 0, 0, 0, 1, 2'b11, 2'd0, 0, 2'b00, 0, 0, 2'b00));
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input int wf, input int wm,
                             input bit zero, input int abort_at);
        bit ok;
        cur_op = op;
        mem_phase("fetch", S_FETCH, wf, -1, ok);
        if (!ok) return;
        push("decode", rb(), rb(), ev(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'd0, 0, 2'b10, 0, 0, 2'b00));
        case (op)
            4'd0: begin
                push("alu_ex", rb(), rb(), ev(S_ALU_EX, 0, 0, 0, 0, 0, 2'b00, 2'd0, 1, 2'b00, 0, 0, 2'b00));
                push("alu_wb", rb(), rb(), ev(S_ALU_WB, 0, 0, 0, 0, 0, 2'b00, 2'd0, 0, 2'b00, 1, 1, 2'b00));
            end
            4'd1: begin
                push("alui_ex", rb(), rb(), ev(S_ALUI_EX, 0, 0, 0, 0, 0, 2'b00, 2'd0, 1, 2'b01, 0, 0, 2'b00));
                push("alui_wb", rb(), rb(), ev(S_ALUI_WB, 0, 0, 0, 0, 0, 2'b00, 2'd0, 0, 2'b00, 1, 1, 2'b01));
            end
            4'd2, 4'd3: begin
                push("ldst_addr", rb(), rb(), ev(S_LDST_ADDR, 0, 0, 0, 0, 0, 2'b00, 2'd0, 1, 2'b10, 0, 0, 2'b00));
                if (op == 4'd2) begin
                    mem_phase("ld", S_LD_MEM, wm, abort_at, ok);
                    if (ok)
                        push("ld_wb", rb(), rb(), ev(S_LD_WB, 0, 0, 0, 0, 0, 2'b00, 2'd0, 0, 2'b00, 1, 0, 2'b01));
                end else begin
                    mem_phase("st", S_ST_MEM, wm, -1, ok);
                end
            end
            4'd4: push("br", rb(), zero, ev(S_BR, 0, 0, 0, 0, zero, 2'b01, 2'd1, 1, 2'b00, 0, 0, 2'b00));
            4'd5: push("jmp", rb(), rb(), ev(S_JMP, 0, 0, 0, 0, 1, 2'b10, 2'd0, 0, 2'b00, 0, 0, 2'b00));
            4'd6: push("jmpi", rb(), rb(), ev(S_JMPI, 0, 0, 0, 0, 1, 2'b00, 2'd0, 0, 2'b00, 0, 0, 2'b00));
            4'd7: begin
                for (int i = 0; i < 5; i++)
                    push("halt", rb(), rb(), ev(S_HALT, 0, 0, 0, 0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 2'b00));
                push_reset("halt_reset");
            end
            default: begin
                m_ill = 1'b1;
                push("ill_trap", rb(), rb(), ev(S_TRAP, 0, 0, 0, 0, 1, 2'b11, 2'd0, 0, 2'b00, 0, 0, 2'b00));
            end
        endcase
    endtask

    function automatic int rand_wait();
        int p = int'($urandom_range(0, 9));
        if (p < 6) return int'($urandom_range(0, 2));
        if (p < 8) return int'($urandom_range(3, 6));
        return int'($urandom_range(13, 18));
    endfunction

    initial begin
        logic [22:0] obs;
        int          r;
        reset = 1'b0; codop = '0; aluZero = 1'b0; memReady = 1'b0;
        cur_op = '0; m_ill = 1'b0; m_bus = 1'b0;

        push_reset("init_reset");
        run_instr(4'd0, 0, 0, 0, -1);          // ALU, memory always ready
        run_instr(4'd2, 0, 3, 0, -1);          // LD with three wait states
        run_instr(4'd4, 0, 0, 1, -1);          // branch taken
        run_instr(4'd4, 0, 0, 0, -1);          // branch not taken
        run_instr(4'hF, 0, 0, 0, -1);          // illegal opcode
        run_instr(4'd0, 1, 0, 0, -1);
        run_instr(4'd3, 0, 100, 0, -1);        // store never acknowledged
        push_reset("pre_boundary");
        run_instr(4'd3, 0, 14, 0, -1);         // ready on the 15th wait cycle
        run_instr(4'd3, 0, 15, 0, -1);         // ready in the timeout cycle
        run_instr(4'd0, 100, 0, 0, -1);        // fetch timeout
        run_instr(4'd7, 0, 0, 0, -1);          // HALT, left by reset
        run_instr(4'd2, 0, 100, 0, 2);         // reset in the middle of LD_MEM
        run_instr(4'd1, 0, 0, 0, -1);

        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 3)       run_instr(4'd0, rand_wait(), 0, 0, -1);
            else if (r < 5)  run_instr(4'd1, rand_wait(), 0, 0, -1);
            else if (r < 8)  run_instr(4'd2, rand_wait(), rand_wait(), 0, -1);
            else if (r < 11) run_instr(4'd3, rand_wait(), rand_wait(), 0, -1);
            else if (r < 14) run_instr(4'd4, rand_wait(), 0, rb(), -1);
            else if (r == 14) run_instr(4'd5, rand_wait(), 0, 0, -1);
            else if (r == 15) run_instr(4'd6, rand_wait(), 0, 0, -1);
            else if (r == 16) run_instr(4'd7, rand_wait(), 0, 0, -1);
            else if (r < 19) run_instr(4'($urandom_range(8, 15)), rand_wait(), 0, 0, -1);
            else run_instr(4'd2, 0, 20, 0, int'($urandom_range(0, 5)));
        end

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            reset    = !plan[i].rst;
            codop    = plan[i].op;
            memReady = plan[i].ready;
            aluZero  = plan[i].zero;
            @(negedge clk);
            obs = {state, memReq, memWrCtl, memAdrSel, irWr, pcCtrl, pcWrSel, aluOp,
                   aluASel, aluBSel, regWCtl, regDataSel, regWSel, illegal, busErr, halted};
            check_eq(plan[i].tag, obs, plan[i].exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
